// File: rtl/id_ex_skid_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_skid_if
// Description : Handshake and payload bundle between the decode stage and
//               the execute stage, as seen around the id/ex skid register.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_skid_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  // Upstream side: decode offers a bundle
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_pc;
  logic [DATA_W-1:0] in_inst;
  logic [DATA_W-1:0] in_reg1;
  logic [DATA_W-1:0] in_reg2;
  logic [DATA_W-1:0] in_imm;
  logic [ADDR_W-1:0] in_reg_waddr;
  logic              in_reg_we;

  // Downstream side: execute consumes the head bundle
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_pc;
  logic [DATA_W-1:0] out_inst;
  logic [DATA_W-1:0] out_reg1;
  logic [DATA_W-1:0] out_reg2;
  logic [DATA_W-1:0] out_imm;
  logic [ADDR_W-1:0] out_reg_waddr;
  logic              out_reg_we;

  // Environment view: drives decode's offer and execute's ready
  modport master (
    output in_valid, in_pc, in_inst, in_reg1, in_reg2, in_imm,
           in_reg_waddr, in_reg_we, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_reg1, out_reg2,
           out_imm, out_reg_waddr, out_reg_we
  );

  // Pipeline-register view: accepts from decode, presents to execute
  modport slave (
    input  in_valid, in_pc, in_inst, in_reg1, in_reg2, in_imm,
           in_reg_waddr, in_reg_we, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_reg1, out_reg2,
           out_imm, out_reg_waddr, out_reg_we
  );

endinterface
`default_nettype wire

// File: rtl/id_ex_skid.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_skid
// Description : Decode-to-execute pipeline register with a 2-entry skid
//               buffer. in_ready comes purely from registered state so an
//               execute stall never creates a combinational path into decode.
//               flush squashes held and incoming entries; writes to x0 are
//               stripped on capture.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_skid #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  wire logic       clk,
  input  wire logic       rst,        // asynchronous, active-low
  input  wire logic       flush,
  id_ex_skid_if.slave     bus,
  output logic [1:0]      occupancy
);

  // Packed entry layout: {pc, inst, reg1, reg2, imm, reg_waddr, reg_we}
  localparam int c_bw = 5 * DATA_W + ADDR_W + 1;

  localparam logic [1:0] c_empty = 2'd0;
  localparam logic [1:0] c_one   = 2'd1;
  localparam logic [1:0] c_full  = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_next;

  logic [c_bw-1:0] r_main;            // head entry, drives out_*
  logic [c_bw-1:0] r_skid;            // second entry, absorbs a stall
  logic [c_bw-1:0] w_in_bundle;

  logic            w_in_we;
  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_acc;
  logic            w_dlv;
  logic            w_main_from_in;
  logic            w_main_from_skid;
  logic            w_skid_from_in;
  logic            w_main_we;

  // A write to x0 is meaningless, so the enable is dropped at capture time
  assign w_in_we     = bus.in_reg_we & (bus.in_reg_waddr != '0);
  assign w_in_bundle = {bus.in_pc, bus.in_inst, bus.in_reg1, bus.in_reg2,
                        bus.in_imm, bus.in_reg_waddr, w_in_we};

  assign w_acc = bus.in_valid & w_in_ready;
  assign w_dlv = w_out_valid & bus.out_ready;

  // State register; flush outranks every handshake transition
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_empty;
    end else if (flush) begin
      r_state <= c_empty;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: occupancy moves by +1 on accept, -1 on deliver
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_empty: begin
        if (w_acc) begin
          w_state_next = c_one;
        end
      end
      c_one: begin
        if (w_acc && !w_dlv) begin
          w_state_next = c_full;
        end else if (!w_acc && w_dlv) begin
          w_state_next = c_empty;
        end
      end
      c_full: begin
        if (w_dlv) begin
          w_state_next = c_one;
        end
      end
      default: begin
        w_state_next = c_empty;
      end
    endcase
  end

  // Status outputs: functions of registered state only
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    occupancy   = 2'd0;
    case (r_state)
      c_empty: begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b0;
        occupancy   = 2'd0;
      end
      c_one: begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b1;
        occupancy   = 2'd1;
      end
      c_full: begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b1;
        occupancy   = 2'd2;
      end
      default: begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        occupancy   = 2'd0;
      end
    endcase
  end

  // Entry steering: which storage slot loads from where this cycle
  always_comb begin
    w_main_from_in   = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_from_in   = 1'b0;
    case (r_state)
      c_empty: begin
        w_main_from_in = w_acc;
      end
      c_one: begin
        // Head leaving while a new one arrives: the newcomer becomes head
        w_main_from_in = w_acc & w_dlv;
        w_skid_from_in = w_acc & ~w_dlv;
      end
      c_full: begin
        w_main_from_skid = w_dlv;
      end
      default: begin
        w_main_from_in   = 1'b0;
      end
    endcase
  end

  // Head entry: cleared on reset/flush, otherwise loads new head when it moves
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main <= '0;
    end else if (flush) begin
      r_main <= '0;
    end else if (w_main_from_in) begin
      r_main <= w_in_bundle;
    end else if (w_main_from_skid) begin
      r_main <= r_skid;
    end
  end

  // Skid entry: only written when the head is stalled and a beat arrives
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_skid <= '0;
    end else if (flush) begin
      r_skid <= '0;
    end else if (w_skid_from_in) begin
      r_skid <= w_in_bundle;
    end
  end

  // Drive the interface from the head entry
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign {bus.out_pc, bus.out_inst, bus.out_reg1, bus.out_reg2,
          bus.out_imm, bus.out_reg_waddr, w_main_we} = r_main;
  // A stale enable in an empty head must never reach execute
  assign bus.out_reg_we = w_main_we & w_out_valid;

endmodule
`default_nettype wire
